alu_muldiv_seq: RTL
===================

Name: alu_muldiv_seq

Overview:
- Multi-cycle sequencer that borrows the shared 64-bit ALU to run iterative unsigned multiply (low 64 bits), unsigned divide and unsigned remainder.
- One ALU add or subtract per cycle; shifts are done in local registers.
- Sits beside the execute stage. The ALU input mux selects this block's drive while busy is high.

Parameters:
- WIDTH, 64, operand/result width; must match the ALU datapath.
- CNT_W, 7, iteration counter width; must hold the value WIDTH.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start  input  1  request pulse; sampled only in IDLE
- op  input  2  0=MUL, 1=UDIV, 2=UREM, 3=reserved (executes as UDIV)
- opa  input  WIDTH  multiplicand / dividend
- opb  input  WIDTH  multiplier / divisor
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse; result valid
- result  output  WIDTH  product, quotient or remainder; held until next accepted start
- div0  output  1  divisor was zero; valid with done, held with result
- alu_ctl  output  5  to ALU ALUCtl
- alu_a  output  WIDTH  to ALU Ain
- alu_b  output  WIDTH  to ALU Bin
- alu_cin  output  1  to ALU carryIn
- alu_out  input  WIDTH  from ALU ALUOut
- alu_status  input  4  from ALU status {V,C,N,Z}; only C (bit 2) is used

Behaviour:
- Reset:
  - state=IDLE; busy=0, done=0, result=0, div0=0.
  - alu_ctl=0, alu_a=0, alu_b=0, alu_cin=0.
  - Internal acc/rem/quot/mcand/mplr/cnt cleared.
  - Reset mid-operation aborts immediately; start is accepted on the first cycle after rst deasserts.
- ALU encodings:
  - ADD: ctl=5'b01000, cin=0.
  - SUB: ctl=5'b01001, cin=1.
  - Idle: all ALU outputs 0.
  - All ALU outputs are registered-state combinational; the ALU result is consumed in the same cycle.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 with op=MUL or UDIV/UREM with opb!=0: latch operands, cnt=0, go RUN.
  - UDIV/UREM with opb==0: go DONE directly. result = 0 for UDIV/reserved, opa for UREM; div0=1.
  - start=0: stay.
- RUN, MUL, one iteration per cycle:
  - alu_a=acc, alu_b=mcand, ADD.
  - If mplr[0]: acc<=alu_out, else acc holds.
  - mcand<=mcand<<1; mplr<=mplr>>1; cnt++.
  - Carries beyond bit 63 are discarded (low-64 product).
- RUN, DIV, restoring division:
  - shifted = {rem[62:0], quot[63]}; msb = rem[63].
  - alu_a=shifted, alu_b=divisor, SUB.
  - If (msb | C): rem<=alu_out, quot<={quot[62:0],1}.
  - Else: rem<=shifted, quot<={quot[62:0],0}.
  - quot is preloaded with the dividend; cnt++.
- RUN exit: when cnt reaches WIDTH-1 in that cycle, go DONE. That is exactly WIDTH iteration cycles.
- DONE (one cycle):
  - done=1.
  - result = acc (MUL), quot (UDIV/reserved) or rem (UREM); div0=0 for a normal run.
  - Next state IDLE.
- Latency: start at edge T0 → RUN for cycles T1..T64 → done high in cycle T65. Divide-by-zero: done high in cycle T1.
- Back-to-back: a start in the IDLE cycle right after DONE is accepted; throughput is one op per 66 cycles.
- start or operand changes during RUN/DONE are ignored; latched operands are used.
- busy=1 only in RUN. done and busy are never high together.

Optional Feature:
- Macro MULDIV_EARLY_EXIT_EN.
- Defined:
  - MUL leaves RUN after the iteration in which the shifted mplr becomes 0.
  - MUL with opb==0 skips RUN: done in cycle T1, result 0.
  - Iterations = index of highest set bit of opb + 1.
  - DIV is unchanged.
- Undefined: every MUL takes exactly WIDTH iterations.

Test Plan:
- MUL opa=7, opb=6 → done at T65, result=42, div0=0; with EARLY_EXIT, done at T4.
- MUL opa=64'hFFFF_FFFF_FFFF_FFFF, opb=2 → result=64'hFFFF_FFFF_FFFF_FFFE (overflow discarded).
- UDIV opa=100, opb=7 → result=14; UREM same operands → result=2; both done at T65.
- UDIV opa=64'hFFFF_FFFF_FFFF_FFFF, opb=64'h8000_0000_0000_0001 → result=1 (msb-carry path). UREM with the same operands → 64'h7FFF_FFFF_FFFF_FFFE.
- UDIV opa=55, opb=0 → done at T1, result=0, div0=1; UREM opa=55, opb=0 → result=55, div0=1.
- rst asserted at T30 of a MUL → next cycle busy=0, done=0, result=0. A start issued the following cycle completes normally. start pulses during RUN do not change the result.

Source files
------------

// File: rtl/alu_muldiv_seq_if.sv
// Bundles the request/response handshake and the shared-ALU drive/return bus of alu_muldiv_seq.
// Latency: none, wires only.
// Backpressure: none; start is only sampled while the sequencer is idle.
interface alu_muldiv_seq_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             div0;
    logic [4:0]       alu_ctl;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_cin;
    logic [WIDTH-1:0] alu_out;
    logic [3:0]       alu_status;

    // Sequencer side: takes requests and ALU returns, drives results and ALU operands.
    modport slave (
        input  start, op, opa, opb, alu_out, alu_status,
        output busy, done, result, div0, alu_ctl, alu_a, alu_b, alu_cin
    );

    // Execute-stage / ALU side.
    modport master (
        output start, op, opa, opb, alu_out, alu_status,
        input  busy, done, result, div0, alu_ctl, alu_a, alu_b, alu_cin
    );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Iterative unsigned MUL (low WIDTH bits) / UDIV / UREM using one shared-ALU add or subtract per cycle.
// Latency: WIDTH RUN cycles then a one-cycle done; divide-by-zero reports done the cycle after start.
// Backpressure: none; start is sampled only in IDLE and ignored while busy or done. MULDIV_EARLY_EXIT_EN ends MUL once the multiplier is exhausted.
module alu_muldiv_seq #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic               clk,
    input  logic               rst,
    alu_muldiv_seq_if.slave    bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [4:0]       CTL_ADD = 5'b01000;
    localparam logic [4:0]       CTL_SUB = 5'b01001;
    localparam logic [1:0]       OP_MUL  = 2'd0;
    localparam logic [1:0]       OP_UREM = 2'd2;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] mcand;   // multiplicand for MUL, divisor for UDIV/UREM
    logic [WIDTH-1:0] mplr;
    logic [WIDTH-1:0] result_q;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       op_q;
    logic             div0_q;
    logic             div0_hold;

    logic             is_mul;
    logic             start_div0;
    logic             skip_run;
    logic             last_iter;
    logic             div_take;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] result_fin;
    logic             unused_status;

    assign is_mul     = (op_q == OP_MUL);
    assign start_div0 = (bus.op != OP_MUL) && (bus.opb == '0);
    assign shifted    = {rem[WIDTH-2:0], quot[WIDTH-1]};
    // A set rem msb means the shifted partial remainder is a WIDTH+1 bit value, always >= divisor.
    assign div_take   = rem[WIDTH-1] | bus.alu_status[2];
    assign result_fin = is_mul ? acc : ((op_q == OP_UREM) ? rem : quot);
    assign unused_status = ^{bus.alu_status[3], bus.alu_status[1:0]};

`ifdef MULDIV_EARLY_EXIT_EN
    assign skip_run  = (bus.opb == '0);
    assign last_iter = (cnt == LAST) || (is_mul && (mplr[WIDTH-1:1] == '0));
`else
    assign skip_run  = start_div0;
    assign last_iter = (cnt == LAST);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: IDLE -> RUN (or straight to DONE when there is nothing to iterate) -> DONE -> IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (bus.start) state_nx = skip_run ? S_DONE : S_RUN;
            S_RUN:   if (last_iter) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs: ALU is driven only in RUN; done reports the live result, otherwise the held copy.
    always_comb begin
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        bus.alu_ctl = '0;
        bus.alu_a   = '0;
        bus.alu_b   = '0;
        bus.alu_cin = 1'b0;
        bus.result  = result_q;
        bus.div0    = div0_hold;
        case (state)
            S_RUN: begin
                bus.busy    = 1'b1;
                bus.alu_ctl = is_mul ? CTL_ADD : CTL_SUB;
                bus.alu_a   = is_mul ? acc : shifted;
                bus.alu_b   = mcand;
                bus.alu_cin = ~is_mul;
            end
            S_DONE: begin
                bus.done   = 1'b1;
                bus.result = result_fin;
                bus.div0   = div0_q;
            end
            default: ;
        endcase
    end

    // Datapath: latch operands on start, one shift-add / restoring-subtract step per RUN cycle, capture result in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            rem       <= '0;
            quot      <= '0;
            mcand     <= '0;
            mplr      <= '0;
            cnt       <= '0;
            op_q      <= '0;
            div0_q    <= 1'b0;
            div0_hold <= 1'b0;
            result_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        op_q   <= bus.op;
                        div0_q <= start_div0;
                        cnt    <= '0;
                        acc    <= '0;
                        mcand  <= (bus.op == OP_MUL) ? bus.opa : bus.opb;
                        mplr   <= bus.opb;
                        // Divide-by-zero preloads the architectural answers: quotient 0, remainder = dividend.
                        rem    <= start_div0 ? bus.opa : '0;
                        quot   <= start_div0 ? '0 : bus.opa;
                    end
                end
                S_RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (is_mul) begin
                        if (mplr[0]) acc <= bus.alu_out;
                        mcand <= mcand << 1;
                        mplr  <= mplr >> 1;
                    end else if (div_take) begin
                        rem  <= bus.alu_out;
                        quot <= {quot[WIDTH-2:0], 1'b1};
                    end else begin
                        rem  <= shifted;
                        quot <= {quot[WIDTH-2:0], 1'b0};
                    end
                end
                S_DONE: begin
                    result_q  <= result_fin;
                    div0_hold <= div0_q;
                end
                default: ;
            endcase
        end
    end
endmodule
